// File: rtl/npu_ldst_pkg.sv
// npu_ldst_pkg: shared state type and default widths for the RF load/store engine
package npu_ldst_pkg;
    localparam int DEF_DATA_W       = 256;
    localparam int DEF_SDRAM_STRIDE = 32;
    typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, LD_WR, ST_RD, ST_REQ, DONE} state_t;
endpackage

// File: rtl/rf_ldst_engine.sv
// rf_ldst_engine: moves line_num lines between the register file and SDRAM, one memory transaction per line
module rf_ldst_engine
    import npu_ldst_pkg::*;
#(
    parameter int RF_ADDR_W    = 10,
    parameter int LINE_NUM_W   = 8,
    parameter int SDRAM_ADDR_W = 32,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SDRAM_STRIDE = DEF_SDRAM_STRIDE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic                    store_start,
    input  logic [RF_ADDR_W-1:0]    rf_addr,
    input  logic [SDRAM_ADDR_W-1:0] sdram_addr,
    input  logic [LINE_NUM_W-1:0]   line_num,
    input  logic                    rf_addr_freeze,
    output logic                    busy,
    output logic                    done,
    output logic                    cmd_err,
    output logic                    rf_we,
    output logic [RF_ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    rf_re,
    output logic [RF_ADDR_W-1:0]    rf_raddr,
    input  logic [DATA_W-1:0]       rf_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [SDRAM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata
);
    state_t                  state;
    logic [RF_ADDR_W-1:0]    rf_cur;
    logic [SDRAM_ADDR_W-1:0] sd_cur;
    logic [LINE_NUM_W-1:0]   cnt;
    logic                    freeze;
    logic [DATA_W-1:0]       data_q;
    logic                    st_first;
    logic                    start;
    logic                    adv;
    logic                    last;
    assign start = load_start | store_start;
    assign adv   = (state == LD_WR) || (state == ST_REQ && mem_gnt);
    assign last  = cnt == LINE_NUM_W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rf_cur   <= '0;
            sd_cur   <= '0;
            cnt      <= '0;
            freeze   <= 1'b0;
            data_q   <= '0;
            st_first <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_err  <= (state == IDLE) ? (load_start & store_start) : start;
            st_first <= state == ST_RD;
            if (state == IDLE && start) begin
                rf_cur <= rf_addr;
                sd_cur <= sdram_addr;
                cnt    <= line_num;
                freeze <= rf_addr_freeze;
            end
            if (adv) begin
                cnt    <= cnt - LINE_NUM_W'(1);
                sd_cur <= sd_cur + SDRAM_ADDR_W'(SDRAM_STRIDE);
                if (!freeze)
                    rf_cur <= rf_cur + RF_ADDR_W'(1);
            end
            if (state == LD_WAIT && mem_rvalid)
                data_q <= mem_rdata;
            // RF read data shows up in the first ST_REQ cycle only
            if (st_first)
                data_q <= rf_rdata;
            case (state)
                IDLE:    if (start) state <= (line_num == '0) ? DONE : load_start ? LD_REQ : ST_RD;
                LD_REQ:  if (mem_gnt) state <= LD_WAIT;
                LD_WAIT: if (mem_rvalid) state <= LD_WR;
                LD_WR:   state <= last ? DONE : LD_REQ;
                ST_RD:   state <= ST_REQ;
                ST_REQ:  if (mem_gnt) state <= last ? DONE : ST_RD;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign rf_we     = state == LD_WR;
    assign rf_re     = state == ST_RD;
    assign mem_req   = (state == LD_REQ) || (state == ST_REQ);
    assign mem_we    = state == ST_REQ;
    assign mem_addr  = sd_cur;
    assign rf_waddr  = rf_cur;
    assign rf_raddr  = rf_cur;
    assign rf_wdata  = data_q;
    assign mem_wdata = st_first ? rf_rdata : data_q;
endmodule

// File: tb/tb_rf_ldst_engine.sv
// tb_rf_ldst_engine: scoreboard bench with RF and SDRAM responder models
module tb_rf_ldst_engine;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start, store_start, rf_addr_freeze;
    logic [9:0]   rf_addr;
    logic [31:0]  sdram_addr;
    logic [7:0]   line_num;
    logic         busy, done, cmd_err, rf_we, rf_re, mem_req, mem_we;
    logic [9:0]   rf_waddr, rf_raddr;
    logic [255:0] rf_wdata, rf_rdata, mem_wdata, mem_rdata;
    logic [31:0]  mem_addr;
    logic         mem_gnt, mem_rvalid;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;
    txn_t mq[$];
    txn_t wq[$];
    txn_t rq[$];

    int errors = 0;
    int checks = 0;
    int gnt_dly = 0;
    int rv_dly = 0;
    int rv_cnt = -1;
    int wait_cnt = 0;
    logic [31:0] rd_addr;

    rf_ldst_engine dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .store_start(store_start),
        .rf_addr(rf_addr), .sdram_addr(sdram_addr), .line_num(line_num), .rf_addr_freeze(rf_addr_freeze),
        .busy(busy), .done(done), .cmd_err(cmd_err),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] sd_val(input logic [31:0] a);
        return {8{a ^ 32'hDEADBEEF}};
    endfunction

    function automatic logic [255:0] rf_val(input logic [9:0] a);
        return {8{22'h2A5A5A, a}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: synchronous read port
    always @(posedge clk) if (rf_re) rf_rdata <= rf_val(rf_raddr);

    // SDRAM responder: grant after gnt_dly waiting cycles, read data rv_dly cycles after the earliest slot
    always @(negedge clk) begin : resp
        txn_t e;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            rv_cnt = -1;
            wait_cnt = 0;
        end else begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = sd_val(rd_addr);
            end
            if (rv_cnt >= 0) rv_cnt--;
            if (!mem_req) wait_cnt = 0;
            else if (mq.size() == 0) chk("mem_req_unexpected", mem_req, 0);
            else begin
                e = mq[0];
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_we", mem_we, e.we);
                if (e.we) chk("mem_wdata", mem_wdata, e.data);
                if (wait_cnt == gnt_dly) begin
                    mem_gnt = 1'b1;
                    wait_cnt = 0;
                    void'(mq.pop_front());
                    if (!e.we) begin
                        rd_addr = mem_addr;
                        rv_cnt = rv_dly;
                    end
                end else wait_cnt++;
            end
        end
    end

    always @(negedge clk) begin : rfmon
        txn_t e;
        if (rst_n) begin
            if (rf_we) begin
                if (wq.size() == 0) chk("rf_we_unexpected", rf_we, 0);
                else begin
                    e = wq.pop_front();
                    chk("rf_waddr", 32'(rf_waddr), e.addr);
                    chk("rf_wdata", rf_wdata, e.data);
                end
            end
            if (rf_re) begin
                if (rq.size() == 0) chk("rf_re_unexpected", rf_re, 0);
                else begin
                    e = rq.pop_front();
                    chk("rf_raddr", 32'(rf_raddr), e.addr);
                end
            end
        end
    end

    task automatic start_cmd(input bit ld, input bit st, input logic [9:0] ra, input logic [31:0] sa,
                             input logic [7:0] n, input bit frz);
        for (int i = 0; i < int'(n); i++) begin
            logic [9:0]  r;
            logic [31:0] s;
            r = frz ? ra : ra + 10'(i);
            s = sa + 32'(32 * i);
            if (ld) begin
                mq.push_back('{1'b0, s, 256'(0)});
                wq.push_back('{1'b0, 32'(r), sd_val(s)});
            end else begin
                rq.push_back('{1'b0, 32'(r), 256'(0)});
                mq.push_back('{1'b1, s, rf_val(r)});
            end
        end
        load_start = ld;
        store_start = st;
        rf_addr = ra;
        sdram_addr = sa;
        line_num = n;
        rf_addr_freeze = frz;
        @(negedge clk);
        load_start = 1'b0;
        store_start = 1'b0;
        chk("busy_cycle1", busy, 1);
        chk("cmd_err_cycle1", cmd_err, ld && st);
    endtask

    task automatic wait_done(input int cyc0, input int exp_cyc, input string tag);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_pending"}, mq.size() + wq.size() + rq.size(), 0);
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done, cmd_err}, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {busy, done, cmd_err, rf_we, rf_re, mem_req, mem_we}, 0);
        chk({tag, "_addr"}, {rf_waddr, rf_raddr, mem_addr}, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0;
        store_start = 1'b0;
        rf_addr = '0;
        sdram_addr = '0;
        line_num = '0;
        rf_addr_freeze = 1'b0;
        rf_rdata = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_cmd(1, 0, 10'h010, 32'h0000_1000, 8'd4, 0);
        wait_done(1, 13, "load4");

        start_cmd(0, 1, 10'h3FF, 32'h0000_2000, 8'd3, 1);
        wait_done(1, 7, "store_freeze");

        gnt_dly = 5;
        rv_dly = 3;
        start_cmd(1, 0, 10'h040, 32'h0000_5000, 8'd2, 0);
        wait_done(1, 23, "load_slow");
        gnt_dly = 0;
        rv_dly = 0;

        start_cmd(1, 0, 10'h3FE, 32'hFFFF_FFE0, 8'd3, 0);
        wait_done(1, 10, "load_wrap");

        start_cmd(1, 0, 10'h100, 32'h0000_6000, 8'd0, 0);
        wait_done(1, 1, "load_zero");

        start_cmd(1, 1, 10'h120, 32'h0000_7000, 8'd2, 0);
        wait_done(1, 7, "both_starts");

        start_cmd(0, 1, 10'h020, 32'h0000_4000, 8'd4, 0);
        @(negedge clk);
        load_start = 1'b1;
        rf_addr = 10'h300;
        sdram_addr = 32'h0000_9000;
        line_num = 8'd9;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_while_busy_err", cmd_err, 1);
        wait_done(3, 9, "store_inject");

        start_cmd(1, 0, 10'h080, 32'h0000_8000, 8'd4, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        rst_n = 1'b1;
        mq.delete();
        wq.delete();
        rq.delete();
        @(negedge clk);
        chk("post_reset_done", {busy, done}, 0);
        start_cmd(1, 0, 10'h090, 32'h0000_A000, 8'd2, 0);
        wait_done(1, 7, "load_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
